bus_word_packer: RTL and testbench

Deserializer that collects `data_size`-bit words arriving one per handshake on a narrow bus and packs `array_size` of them into one wide vector for the processing-element row. It is the write-side counterpart of the row readout serializer: lane 0 occupies the LSBs, so a vector packed here and then serialized lane-0-first reproduces the original word order. It sits between the byte-wide input stream and the wide operand registers of the CNN array.

---
 rtl/bus_word_packer.sv | 145 ++++++++++++++
 tb/tb_bus_word_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_word_packer.sv
// -----------------------------------------------------------------------------
// bus_word_packer
//
// Collects data_size-bit words arriving one per handshake on a narrow input
// bus and packs array_size of them into one wide vector for the
// processing-element row. Lane 0 sits in the LSBs, so a vector packed here
// and later serialized lane-0-first reproduces the original word order.
//
// Handshake rule (both sides): a transfer happens on a rising edge of r_clk
// when valid and ready are both high in that cycle. valid, once raised, is
// held with stable data until the transfer; ready may change freely.
//
// Ports
//   r_clk      in   clock, all logic on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_data    in   incoming word
//   in_valid   in   in_data valid
//   in_ready   out  packer can accept a word this cycle
//   flush      in   single-cycle request to close a partially filled vector
//   out_data   out  packed vector, lane k at [k*data_size +: data_size]
//   out_count  out  number of lanes written in out_data (1..array_size)
//   out_valid  out  out_data/out_count valid
//   out_ready  in   consumer takes the vector this cycle
//   dbg_state  out  current FSM state (0 = FILL, 1 = HOLD)
// -----------------------------------------------------------------------------
module bus_word_packer #(
    parameter int array_size = 9,
    parameter int data_size  = 8
) (
    input  logic                                r_clk,
    input  logic                                rst_n,
    input  logic [data_size-1:0]                in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic [data_size*array_size-1:0]     out_data,
    output logic [$clog2(array_size+1)-1:0]     out_count,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                dbg_state
);

    localparam int cw = $clog2(array_size + 1);
    localparam int vw = data_size * array_size;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic [vw-1:0]     pack_q, pack_d;
    logic [cw-1:0]     count_q, count_d;

    logic              accept;
    logic              taken;
    logic              open_vec;
    logic              flush_ok;
    logic              close_vec;
    logic [cw-1:0]     base_cnt;
    logic [cw-1:0]     fill_cnt;
    logic [vw-1:0]     base_pack;
    logic [vw-1:0]     wr_pack;

    // -------------------------------------------------------------------------
    // Handshake and datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        // In HOLD the only way to take a new word is to release the held
        // vector in the same cycle, hence in_ready follows out_ready there.
        in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
        out_valid = (state_q == HOLD);
        accept    = in_valid && in_ready;
        taken     = out_valid && out_ready;

        // A vector is being assembled this cycle either because we are
        // filling, or because the held vector leaves and a fresh one starts.
        open_vec  = (state_q == FILL) || taken;

        // A fresh vector starts from an all-zero register at lane 0, so
        // stale lanes from the previous vector never leak through.
        base_cnt  = (state_q == HOLD) ? '0 : cnt_q;
        base_pack = (state_q == HOLD) ? '0 : pack_q;
        fill_cnt  = base_cnt + (accept ? cw'(1) : cw'(0));

        wr_pack = base_pack;
        for (int k = 0; k < array_size; k++) begin
            if (accept && (base_cnt == cw'(k))) begin
                wr_pack[k*data_size +: data_size] = in_data;
            end
        end

        // flush only counts while filling; a flush with nothing written
        // (and no word arriving alongside it) is dropped.
        flush_ok  = flush && (state_q == FILL) && (fill_cnt != '0);
        close_vec = (accept && (base_cnt == cw'(array_size - 1))) || flush_ok;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        count_d = count_q;

        if (open_vec) begin
            pack_d  = wr_pack;
            cnt_d   = fill_cnt;
            count_d = '0;
            state_d = FILL;
            if (close_vec) begin
                // The word of this cycle (if any) is already in wr_pack,
                // so fill_cnt is the exact number of lanes in the vector.
                state_d = HOLD;
                count_d = fill_cnt;
                cnt_d   = '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            pack_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            count_q <= count_d;
        end
    end

    assign out_data  = pack_q;
    assign out_count = count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_word_packer.sv
module tb_bus_word_packer;

  localparam int AS = 9;
  localparam int DS = 8;
  localparam int CW = $clog2(AS + 1);
  localparam int VW = AS * DS;

  logic          r_clk;
  logic          rst_n;
  logic [DS-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [VW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;
  logic          dbg_state;

  int tests_run;
  int tests_failed;

  logic [VW-1:0] exp_vec;
  logic [VW-1:0] held_vec;

  bus_word_packer #(
    .array_size (AS),
    .data_size  (DS)
  ) dut (
    .r_clk     (r_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // one clock edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one word for one cycle (word is accepted if in_ready is high)
  task automatic send(input logic [DS-1:0] d, input logic fl);
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_in_ready", VW'(in_ready), VW'(1));
    check("rst_out_data", out_data, '0);
    check("rst_out_count", VW'(out_count), VW'(0));
    check("rst_state", VW'(dbg_state), VW'(0));

    // ---------------- full vector ----------------
    out_ready = 1'b1;
    for (int i = 0; i < AS; i++) begin
      check("full_in_ready", VW'(in_ready), VW'(1));
      send(DS'(9 - i), 1'b0);
      if (i < AS - 1) check("full_no_valid_early", VW'(out_valid), VW'(0));
    end
    check("full_out_valid", VW'(out_valid), VW'(1));
    check("full_out_data", out_data, 72'h010203040506070809);
    check("full_out_count", VW'(out_count), VW'(9));
    idle();
    check("full_taken_valid", VW'(out_valid), VW'(0));
    check("full_taken_cleared", out_data, '0);

    // ---------------- back-pressure ----------------
    out_ready = 1'b0;
    for (int i = 0; i < AS; i++) send(DS'(8'h10 + i), 1'b0);
    held_vec = 72'h181716151413121110;
    check("bp_out_valid", VW'(out_valid), VW'(1));
    check("bp_out_data", out_data, held_vec);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready_low", VW'(in_ready), VW'(0));
      tick();
      check("bp_valid_held", VW'(out_valid), VW'(1));
      check("bp_data_stable", out_data, held_vec);
      check("bp_count_stable", VW'(out_count), VW'(9));
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_follow", VW'(in_ready), VW'(1));
    tick();
    in_valid = 1'b0;
    check("bp_released_valid", VW'(out_valid), VW'(0));
    check("bp_aa_lane0", out_data, 72'h0000000000000000AA);
    for (int i = 1; i < AS; i++) send(DS'(i), 1'b0);
    check("bp_next_valid", VW'(out_valid), VW'(1));
    check("bp_next_data", out_data, 72'h0807060504030201AA);
    idle();

    // ---------------- partial flush ----------------
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("pf_no_valid_yet", VW'(out_valid), VW'(0));
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("pf_out_valid", VW'(out_valid), VW'(1));
    check("pf_out_data", out_data, 72'h000000000000332211);
    check("pf_out_count", VW'(out_count), VW'(3));
    idle();
    check("pf_taken", VW'(out_valid), VW'(0));

    // flush on an empty packer produces nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush_valid", VW'(out_valid), VW'(0));
    check("empty_flush_data", out_data, '0);
    idle();
    check("empty_flush_valid2", VW'(out_valid), VW'(0));

    // ---------------- flush with the 9th word ----------------
    for (int i = 0; i < AS - 1; i++) send(DS'(8'h21 + i), 1'b0);
    send(8'h29, 1'b1);
    check("f9_out_valid", VW'(out_valid), VW'(1));
    check("f9_out_count", VW'(out_count), VW'(9));
    check("f9_out_data", out_data, 72'h292827262524232221);
    idle();
    check("f9_single_vector", VW'(out_valid), VW'(0));

    // ---------------- flush with the 2nd word ----------------
    send(8'h31, 1'b0);
    send(8'h32, 1'b1);
    check("f2_out_valid", VW'(out_valid), VW'(1));
    check("f2_out_count", VW'(out_count), VW'(2));
    check("f2_out_data", out_data, 72'h000000000000003231);
    idle();

    // ---------------- continuous stream of 27 words ----------------
    exp_vec = '0;
    for (int i = 0; i < 3 * AS; i++) begin
      check("st_in_ready", VW'(in_ready), VW'(1));
      exp_vec[(i % AS) * DS +: DS] = DS'(8'h40 + i);
      send(DS'(8'h40 + i), 1'b0);
      if ((i % AS) == AS - 1) begin
        check("st_out_valid", VW'(out_valid), VW'(1));
        check("st_out_data", out_data, exp_vec);
        check("st_out_count", VW'(out_count), VW'(9));
        exp_vec = '0;
      end else begin
        check("st_no_valid", VW'(out_valid), VW'(0));
      end
    end
    idle();

    // ---------------- reset mid-fill ----------------
    for (int i = 0; i < 4; i++) send(DS'(8'hE1 + i), 1'b0);
    rst_n = 1'b0;
    tick();
    check("rmf_valid", VW'(out_valid), VW'(0));
    check("rmf_data", out_data, '0);
    rst_n = 1'b1;
    for (int i = 0; i < AS; i++) send(DS'(8'h51 + i), 1'b0);
    check("rmf_clean_valid", VW'(out_valid), VW'(1));
    check("rmf_clean_data", out_data, 72'h595857565554535251);
    check("rmf_clean_count", VW'(out_count), VW'(9));
    idle();

    // ---------------- reset in HOLD ----------------
    out_ready = 1'b0;
    for (int i = 0; i < AS; i++) send(DS'(8'hC1 + i), 1'b0);
    check("rh_held", VW'(out_valid), VW'(1));
    rst_n = 1'b0;
    tick();
    check("rh_valid", VW'(out_valid), VW'(0));
    check("rh_count", VW'(out_count), VW'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < AS; i++) send(DS'(8'h61 + i), 1'b0);
    check("rh_clean_valid", VW'(out_valid), VW'(1));
    check("rh_clean_data", out_data, 72'h696867666564636261);
    check("rh_clean_count", VW'(out_count), VW'(9));
    idle();
    check("rh_end_idle", VW'(out_valid), VW'(0));

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
